// File: rtl/mem_arbiter_rr_if.sv
// Bus bundle for mem_arbiter_rr: N requester line ports plus one downstream line port.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_rr_if #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned ADDR_W  = 32
);
  logic [N_PORTS-1:0]        req_read;
  logic [N_PORTS-1:0]        req_write;
  logic [N_PORTS*ADDR_W-1:0] req_address;
  logic [N_PORTS*LINE_W-1:0] req_wdata;
  logic [LINE_W-1:0]         req_rdata;
  logic [N_PORTS-1:0]        req_resp;

  logic                      pmem_read;
  logic                      pmem_write;
  logic [ADDR_W-1:0]         pmem_address;
  logic [LINE_W-1:0]         pmem_wdata;
  logic [LINE_W-1:0]         pmem_rdata;
  logic                      pmem_resp;

  modport slave (
    input  req_read, req_write, req_address, req_wdata, pmem_rdata, pmem_resp,
    output req_rdata, req_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output req_read, req_write, req_address, req_wdata, pmem_rdata, pmem_resp,
    input  req_rdata, req_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Round-robin N-port cache-line arbiter with a registered downstream request.
// Define ARB_WRITE_FIRST_EN to give pending writes priority over reads in IDLE.
module mem_arbiter_rr #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  mem_arbiter_rr_if.slave    bus,
  output logic [IDX_W-1:0]   grant_idx_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   grant_idx_q;
  logic [N_PORTS-1:0] mask_q;
  logic [N_PORTS-1:0] req_resp_q;
  logic               pmem_read_q;
  logic               pmem_write_q;
  logic [ADDR_W-1:0]  pmem_address_q;
  logic [LINE_W-1:0]  pmem_wdata_q;
  logic [LINE_W-1:0]  req_rdata_q;

  logic [N_PORTS-1:0] pend;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   win_idx;
  logic               win_valid;

`ifdef ARB_WRITE_FIRST_EN
  logic [N_PORTS-1:0] wpend;
`endif

  // Winner search: walk the ring backwards so the last hit is the first port from rr_ptr.
  always_comb begin
    pend      = (bus.req_read | bus.req_write) & ~mask_q;
`ifdef ARB_WRITE_FIRST_EN
    wpend     = bus.req_write & ~mask_q;
    if (|wpend) begin
      pend = wpend;
    end
`endif
    cand      = '0;
    win_idx   = '0;
    win_valid = 1'b0;
    for (int k = int'(N_PORTS) - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % int'(N_PORTS));
      if (pend[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      rr_ptr_q       <= '0;
      grant_idx_q    <= '0;
      mask_q         <= '0;
      req_resp_q     <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      req_rdata_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          mask_q <= '0;
          if (win_valid) begin
            pmem_address_q <= bus.req_address[int'(win_idx) * int'(ADDR_W) +: ADDR_W];
            pmem_wdata_q   <= bus.req_wdata[int'(win_idx) * int'(LINE_W) +: LINE_W];
            // Write dominates if a port illegally raises both.
            pmem_write_q   <= bus.req_write[win_idx];
            pmem_read_q    <= bus.req_read[win_idx] & ~bus.req_write[win_idx];
            grant_idx_q    <= win_idx;
            state_q        <= StBusy;
          end
        end
        StBusy: begin
          if (bus.pmem_resp) begin
            req_rdata_q  <= bus.pmem_rdata;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            req_resp_q   <= N_PORTS'(1) << grant_idx_q;
            state_q      <= StResp;
          end
        end
        StResp: begin
          req_resp_q <= '0;
          rr_ptr_q   <= (grant_idx_q == IDX_W'(N_PORTS - 1)) ? '0 : grant_idx_q + 1'b1;
          // Mask the just-served port for one IDLE cycle to absorb a late request drop.
          mask_q     <= N_PORTS'(1) << grant_idx_q;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_rdata    = req_rdata_q;
  assign bus.req_resp     = req_resp_q;
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = pmem_address_q;
  assign bus.pmem_wdata   = pmem_wdata_q;
  assign grant_idx_o      = grant_idx_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: a per-cycle vector table on a 2-port instance,
// then hand sequences for write stability, mid-transaction reset and write-first priority.
module tb_mem_arbiter_rr;

  localparam int unsigned LW = 256;
  localparam int unsigned AW = 32;

  localparam logic [LW-1:0] LA = {8{32'hA5A5_A5A5}};
  localparam logic [LW-1:0] LB = {8{32'h3C3C_0F0F}};
  localparam logic [LW-1:0] LC = {8{32'h1234_5678}};
  localparam logic [LW-1:0] W0 = {32'hDEAD_0001, {6{32'h0000_0000}}, 32'h0000_BEEF};
  localparam logic [LW-1:0] W1 = {8{32'h0F0F_F0F0}};
  localparam logic [AW-1:0] A0 = 32'h0000_0080;
  localparam logic [AW-1:0] A1 = 32'h0000_1240;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] gidx2;
  logic [1:0] gidx3;

  always #5 clk = ~clk;

  mem_arbiter_rr_if #(.N_PORTS(2), .LINE_W(LW), .ADDR_W(AW)) bus2 ();
  mem_arbiter_rr_if #(.N_PORTS(3), .LINE_W(LW), .ADDR_W(AW)) bus3 ();

  mem_arbiter_rr #(.N_PORTS(2), .LINE_W(LW), .ADDR_W(AW)) u_dut2 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus2.slave),
    .grant_idx_o (gidx2)
  );

  mem_arbiter_rr #(.N_PORTS(3), .LINE_W(LW), .ADDR_W(AW)) u_dut3 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus3.slave),
    .grant_idx_o (gidx3)
  );

  typedef struct {
    logic          rst;
    logic [1:0]    rd;
    logic [1:0]    wr;
    logic          presp;
    logic [LW-1:0] prdata;
    logic          e_rd;
    logic          e_wr;
    logic [1:0]    e_resp;
    logic          e_gidx;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_rdata;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic r, input logic [1:0] rd, input logic [1:0] wr,
                              input logic p, input logic [LW-1:0] prd,
                              input logic erd, input logic ewr, input logic [1:0] eresp,
                              input logic eg, input logic [AW-1:0] ea,
                              input logic [LW-1:0] erdata);
    vec_t v;
    v.rst = r; v.rd = rd; v.wr = wr; v.presp = p; v.prdata = prd;
    v.e_rd = erd; v.e_wr = ewr; v.e_resp = eresp; v.e_gidx = eg;
    v.e_addr = ea; v.e_rdata = erdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] first;
  logic [1:0] second;

  initial begin
    rst               = 1'b1;
    bus2.req_read     = '0;
    bus2.req_write    = '0;
    bus2.req_address  = {A1, A0};
    bus2.req_wdata    = {W1, W0};
    bus2.pmem_rdata   = '0;
    bus2.pmem_resp    = 1'b0;
    bus3.req_read     = '0;
    bus3.req_write    = '0;
    bus3.req_address  = {32'h0000_0320, 32'h0000_0310, 32'h0000_0300};
    bus3.req_wdata    = '0;
    bus3.pmem_rdata   = '0;
    bus3.pmem_resp    = 1'b0;

    // rst rd wr presp prdata | e_rd e_wr e_resp e_gidx e_addr e_rdata
    vecs.push_back(mk(1, 2'b00, 2'b00, 0, '0, 0, 0, 2'b00, 0, '0, '0));
    vecs.push_back(mk(1, 2'b00, 2'b00, 0, '0, 0, 0, 2'b00, 0, '0, '0));
    vecs.push_back(mk(0, 2'b10, 2'b00, 0, '0, 1, 0, 2'b00, 1, A1, '0));
    vecs.push_back(mk(0, 2'b10, 2'b00, 0, LC, 1, 0, 2'b00, 1, A1, '0));
    vecs.push_back(mk(0, 2'b10, 2'b00, 0, '0, 1, 0, 2'b00, 1, A1, '0));
    vecs.push_back(mk(0, 2'b10, 2'b00, 1, LA, 0, 0, 2'b10, 1, A1, LA));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0, '0, 0, 0, 2'b00, 1, A1, LA));
    vecs.push_back(mk(0, 2'b11, 2'b00, 0, '0, 1, 0, 2'b00, 0, A0, LA));
    vecs.push_back(mk(0, 2'b11, 2'b00, 1, LB, 0, 0, 2'b01, 0, A0, LB));
    vecs.push_back(mk(0, 2'b11, 2'b00, 0, '0, 0, 0, 2'b00, 0, A0, LB));
    vecs.push_back(mk(0, 2'b11, 2'b00, 0, '0, 1, 0, 2'b00, 1, A1, LB));
    vecs.push_back(mk(0, 2'b11, 2'b00, 1, LC, 0, 0, 2'b10, 1, A1, LC));
    vecs.push_back(mk(0, 2'b11, 2'b00, 0, '0, 0, 0, 2'b00, 1, A1, LC));
    vecs.push_back(mk(0, 2'b11, 2'b00, 0, '0, 1, 0, 2'b00, 0, A0, LC));
    vecs.push_back(mk(0, 2'b11, 2'b00, 1, LA, 0, 0, 2'b01, 0, A0, LA));
    vecs.push_back(mk(0, 2'b11, 2'b00, 0, '0, 0, 0, 2'b00, 0, A0, LA));
    vecs.push_back(mk(0, 2'b11, 2'b00, 0, '0, 1, 0, 2'b00, 1, A1, LA));
    vecs.push_back(mk(0, 2'b11, 2'b00, 1, LB, 0, 0, 2'b10, 1, A1, LB));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0, '0, 0, 0, 2'b00, 1, A1, LB));
    // Late drop: port0 still requesting in the masked IDLE cycle.
    vecs.push_back(mk(0, 2'b01, 2'b00, 0, '0, 1, 0, 2'b00, 0, A0, LB));
    vecs.push_back(mk(0, 2'b01, 2'b00, 1, LC, 0, 0, 2'b01, 0, A0, LC));
    vecs.push_back(mk(0, 2'b01, 2'b00, 0, '0, 0, 0, 2'b00, 0, A0, LC));
    vecs.push_back(mk(0, 2'b01, 2'b00, 0, '0, 0, 0, 2'b00, 0, A0, LC));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0, '0, 0, 0, 2'b00, 0, A0, LC));
    vecs.push_back(mk(0, 2'b01, 2'b00, 0, '0, 1, 0, 2'b00, 0, A0, LC));
    vecs.push_back(mk(0, 2'b01, 2'b00, 1, LA, 0, 0, 2'b01, 0, A0, LA));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0, '0, 0, 0, 2'b00, 0, A0, LA));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0, '0, 0, 0, 2'b00, 0, A0, LA));
    // Write with read also asserted: write wins.
    vecs.push_back(mk(0, 2'b01, 2'b01, 0, '0, 0, 1, 2'b00, 0, A0, LA));
    vecs.push_back(mk(0, 2'b01, 2'b01, 0, '0, 0, 1, 2'b00, 0, A0, LA));
    vecs.push_back(mk(0, 2'b01, 2'b01, 1, LB, 0, 0, 2'b01, 0, A0, LB));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0, '0, 0, 0, 2'b00, 0, A0, LB));

    foreach (vecs[i]) begin
      rst             = vecs[i].rst;
      bus2.req_read   = vecs[i].rd;
      bus2.req_write  = vecs[i].wr;
      bus2.pmem_resp  = vecs[i].presp;
      bus2.pmem_rdata = vecs[i].prdata;
      tick();
      chk($sformatf("v%0d pmem_read", i),    LW'(bus2.pmem_read),    LW'(vecs[i].e_rd));
      chk($sformatf("v%0d pmem_write", i),   LW'(bus2.pmem_write),   LW'(vecs[i].e_wr));
      chk($sformatf("v%0d req_resp", i),     LW'(bus2.req_resp),     LW'(vecs[i].e_resp));
      chk($sformatf("v%0d grant_idx", i),    LW'(gidx2),             LW'(vecs[i].e_gidx));
      chk($sformatf("v%0d pmem_address", i), LW'(bus2.pmem_address), LW'(vecs[i].e_addr));
      chk($sformatf("v%0d req_rdata", i),    bus2.req_rdata,         vecs[i].e_rdata);
    end
    bus2.pmem_resp = 1'b0;

    // Write path: latched address/wdata must not follow requester inputs during BUSY.
    rst = 1'b1;
    tick();
    rst            = 1'b0;
    bus2.req_read  = 2'b01;
    bus2.req_write = 2'b01;
    tick();
    chk("wr pmem_write",   LW'(bus2.pmem_write),   LW'(1'b1));
    chk("wr pmem_read",    LW'(bus2.pmem_read),    LW'(1'b0));
    chk("wr pmem_address", LW'(bus2.pmem_address), LW'(A0));
    chk("wr pmem_wdata",   bus2.pmem_wdata,        W0);
    bus2.req_address = {A1, 32'hFFFF_0000};
    bus2.req_wdata   = {W1, ~W0};
    bus2.req_read    = 2'b10;
    bus2.req_write   = 2'b00;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("wr hold%0d pmem_address", c), LW'(bus2.pmem_address), LW'(A0));
      chk($sformatf("wr hold%0d pmem_wdata", c),   bus2.pmem_wdata,        W0);
      chk($sformatf("wr hold%0d pmem_write", c),   LW'(bus2.pmem_write),   LW'(1'b1));
      chk($sformatf("wr hold%0d grant_idx", c),    LW'(gidx2),             LW'(1'b0));
    end
    bus2.pmem_resp  = 1'b1;
    bus2.pmem_rdata = LC;
    tick();
    chk("wr req_resp",   LW'(bus2.req_resp),   LW'(2'b01));
    chk("wr pmem_write", LW'(bus2.pmem_write), LW'(1'b0));
    chk("wr req_rdata",  bus2.req_rdata,       LC);
    bus2.pmem_resp   = 1'b0;
    bus2.req_read    = 2'b00;
    bus2.req_address = {A1, A0};
    bus2.req_wdata   = {W1, W0};
    tick();
    chk("wr resp pulse", LW'(bus2.req_resp), LW'(2'b00));

    // Reset held two cycles mid-transaction, then a stray pmem_resp in IDLE.
    bus2.req_read = 2'b10;
    tick();
    chk("rst pre pmem_read", LW'(bus2.pmem_read), LW'(1'b1));
    chk("rst pre grant_idx", LW'(gidx2),          LW'(1'b1));
    rst           = 1'b1;
    bus2.req_read = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    chk("rst pmem_read",    LW'(bus2.pmem_read),    '0);
    chk("rst pmem_write",   LW'(bus2.pmem_write),   '0);
    chk("rst pmem_address", LW'(bus2.pmem_address), '0);
    chk("rst pmem_wdata",   bus2.pmem_wdata,        '0);
    chk("rst req_rdata",    bus2.req_rdata,         '0);
    chk("rst req_resp",     LW'(bus2.req_resp),     '0);
    chk("rst grant_idx",    LW'(gidx2),             '0);
    bus2.pmem_resp  = 1'b1;
    bus2.pmem_rdata = LB;
    tick();
    chk("idle presp req_resp",  LW'(bus2.req_resp),  '0);
    chk("idle presp req_rdata", bus2.req_rdata,      '0);
    chk("idle presp pmem_read", LW'(bus2.pmem_read), '0);
    bus2.pmem_resp = 1'b0;
    tick();
    chk("idle presp req_resp2", LW'(bus2.req_resp), '0);

    // Three ports: port0 reads while port2 writes, from rr_ptr=0.
`ifdef ARB_WRITE_FIRST_EN
    first  = 2'd2;
    second = 2'd0;
`else
    first  = 2'd0;
    second = 2'd2;
`endif
    rst = 1'b1;
    tick();
    rst            = 1'b0;
    bus3.req_read  = 3'b001;
    bus3.req_write = 3'b100;
    tick();
    chk("n3 first grant_idx",  LW'(gidx3),           LW'(first));
    chk("n3 first pmem_write", LW'(bus3.pmem_write), LW'(first == 2'd2));
    chk("n3 first pmem_read",  LW'(bus3.pmem_read),  LW'(first == 2'd0));
    chk("n3 first address",    LW'(bus3.pmem_address),
        LW'((first == 2'd2) ? 32'h0000_0320 : 32'h0000_0300));
    bus3.pmem_resp = 1'b1;
    tick();
    chk("n3 first req_resp", LW'(bus3.req_resp), LW'(3'b001 << first));
    bus3.pmem_resp = 1'b0;
    if (first == 2'd2) bus3.req_write = 3'b000;
    else               bus3.req_read  = 3'b000;
    tick();
    tick();
    chk("n3 second grant_idx", LW'(gidx3), LW'(second));
    bus3.pmem_resp = 1'b1;
    tick();
    chk("n3 second req_resp", LW'(bus3.req_resp), LW'(3'b001 << second));
    bus3.pmem_resp = 1'b0;
    bus3.req_read  = '0;
    bus3.req_write = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
